branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the RV32I five-stage pipeline: a direct-mapped branch target buffer (BTB) plus a saturating-counter branch history table (BHT).
- Replaces the static predict-not-taken policy. In IF it supplies a predicted next PC for the current fetch PC.
- In EX it takes the resolved branch or jump outcome, updates its tables, and raises a mispredict redirect that the hazard unit uses to flush IF/ID.

Parameters:
- ENTRIES, 64, number of BTB/BHT entries; power of two, 4..1024; IDX_W = log2(ENTRIES).
- TAG_W, 8, stored tag width; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2].
- CNT_W, 2, BHT counter width; taken threshold = 2^(CNT_W-1).
- PC_W, 32, PC and target width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- if_pc  in  PC_W  current fetch PC (PC_IF).
- pred_taken  out  1  IF prediction: taken.
- pred_target  out  PC_W  IF predicted next PC.
- upd_valid  in  1  EX holds a real control-transfer instruction (low on bubble or flush).
- upd_is_br  in  1  EX instruction is a conditional branch (0 = jal/jalr).
- upd_pc  in  PC_W  PC of the EX instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  PC_W  resolved target.
- upd_pred_taken  in  1  prediction made for this instruction, piped IF→EX.
- upd_pred_target  in  PC_W  predicted target, piped IF→EX.
- mispredict  out  1  EX redirect required.
- redirect_pc  out  PC_W  correct next PC when mispredict = 1.

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[PC_W], cnt[CNT_W]. All entries are registers.
- Reset (rst = 0, asynchronous): every valid = 0, every cnt = 2^(CNT_W-1)-1 (weakly not-taken, 01 for CNT_W = 2). Reset asserted mid-update discards that update.
- Lookup (combinational, zero latency): idx = if_pc[IDX_W+1:2].
  - hit = valid[idx] && tag[idx] == if_pc tag field.
  - pred_taken = hit && cnt[idx] >= threshold.
  - pred_target = pred_taken ? target[idx] : if_pc + 4.
  - During reset, outputs follow the cleared tables: pred_taken = 0, pred_target = if_pc + 4.
- Resolution (combinational): when upd_valid = 1, mispredict = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target). When upd_valid = 0, mispredict = 0.
- redirect_pc = upd_taken ? upd_target : upd_pc + 4.
- Update (rising edge, only when upd_valid = 1); uidx and utag are taken from upd_pc:
  - Entry hit, or upd_taken = 1: write valid = 1, tag = utag. If upd_taken, also write target = upd_target.
  - Allocation on a miss with upd_taken = 1 initialises cnt = threshold (weakly taken).
  - Entry hit: cnt saturating ±1 in the direction of upd_taken. No wrap past 0 or 2^CNT_W-1.
  - Miss with upd_taken = 0: no write.
  - upd_is_br = 0 (jal/jalr): cnt is forced to all-ones on write.
- Simultaneous lookup and update to the same index in one cycle: lookup returns the pre-update contents (no bypass). The new contents become visible the next cycle.
- Aliasing: a tag collision replaces the entry (direct-mapped, no replacement policy).
- Arithmetic: PC additions are modulo 2^PC_W. Bits pc[1:0] are ignored.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds three output ports: stat_branches[31:0], stat_mispred[31:0], stat_btb_hits[31:0].
  - stat_branches increments on each upd_valid.
  - stat_mispred increments on each mispredict.
  - stat_btb_hits increments on each lookup hit.
  - All three reset to 0, wrap at 2^32, and update on the rising edge.
- When undefined, these ports and counters do not exist and the area is identical to the base design.

Decomposition:
- Shared package bp_pkg holds:
  - counter-update function sat_update(cnt, taken);
  - localparams IDX_W and threshold;
  - the entry struct typedef bp_entry_t {valid, tag, target, cnt}.
- One natural sub-module: bp_sat_counter_array, the ENTRIES × CNT_W counter file with its asynchronous reset and saturating update. The BTB tag/target array stays in the top module.

Test Plan:
- Reset, then if_pc = 0x0000_0100 → pred_taken = 0, pred_target = 0x0000_0104. Drive upd_valid = 1 with upd_pc = 0x100, upd_taken = 1, upd_target = 0x80, upd_pred_taken = 0 → mispredict = 1, redirect_pc = 0x80.
- Next cycle, if_pc = 0x100 → hit, cnt = 2, pred_taken = 1, pred_target = 0x80. Resolve taken with matching prediction → mispredict = 0, cnt saturates at 3 after two more taken updates.
- Loop exit: entry at cnt = 3, resolve not-taken twice → cnt = 1, prediction for 0x100 becomes not-taken. The first not-taken resolve gives mispredict = 1, redirect_pc = 0x104.
- Alias: ENTRIES = 64, allocate 0x100, then taken branch at 0x200 (same idx) → lookup of 0x100 misses, 0x200 hits.
- Same-cycle collision: update and lookup at idx of 0x300 in one cycle → lookup shows the old miss, and the hit appears the following cycle. Assert rst during an update edge → tables are cleared and the update is lost.
- With BP_STATS_EN: 10 resolves, 3 mispredicts → stat_branches = 10, stat_mispred = 3.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter update ops,
// the BTB entry layout at default widths, and the saturating counter step.
package bp_pkg;

  localparam int DEF_ENTRIES = 64;
  localparam int DEF_TAG_W   = 8;
  localparam int DEF_CNT_W   = 2;
  localparam int DEF_PC_W    = 32;
  localparam int IDX_W       = $clog2(DEF_ENTRIES);
  localparam int THRESHOLD   = 2 ** (DEF_CNT_W - 1);
  localparam int MAX_CNT_W   = 8;

  typedef enum logic [1:0] {
    CNT_SAT        = 2'd0,
    CNT_SET_WEAK_T = 2'd1,
    CNT_SET_MAX    = 2'd2
  } cnt_op_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_PC_W-1:0]  target;
    logic [DEF_CNT_W-1:0] cnt;
  } bp_entry_t;

  // One step toward the resolved direction, clamped to [0, 2^cnt_w-1].
  function automatic logic [MAX_CNT_W-1:0] sat_update(
    input logic [MAX_CNT_W-1:0] cnt,
    input logic                 taken,
    input int unsigned          cnt_w
  );
    logic [MAX_CNT_W-1:0] top;
    top = MAX_CNT_W'((1 << cnt_w) - 1);
    if (taken) return (cnt == top) ? cnt : cnt + 1'b1;
    else       return (cnt == '0)  ? cnt : cnt - 1'b1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_array.sv
// BHT counter file: ENTRIES saturating counters, one combinational read port
// for lookup and one write port for resolution, cleared to weakly not-taken.
module bp_sat_counter_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic [CNT_W-1:0]           rd_cnt,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  cnt_op_t                    wr_op,
  input  logic                       wr_taken
);

  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(2 ** (CNT_W - 1));
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(2 ** (CNT_W - 1) - 1);

  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] nxt_cnt;

  assign rd_cnt  = cnt_q[rd_idx];
  assign cur_cnt = cnt_q[wr_idx];

  always_comb begin
    nxt_cnt = cur_cnt;
    unique case (wr_op)
      CNT_SAT:        nxt_cnt = CNT_W'(sat_update(MAX_CNT_W'(cur_cnt), wr_taken, CNT_W));
      CNT_SET_WEAK_T: nxt_cnt = WEAK_T;
      CNT_SET_MAX:    nxt_cnt = '1;
      default:        nxt_cnt = cur_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WEAK_NT;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= nxt_cnt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus saturating-counter BHT.
// Define BP_STATS_EN to add branch, mispredict and BTB-hit statistics counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_is_br,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred,
  output logic [31:0]     stat_btb_hits
`endif
);

  localparam int               IW     = $clog2(ENTRIES);
  localparam int               TAG_LO = IW + 2;
  localparam logic [CNT_W-1:0] THR    = CNT_W'(2 ** (CNT_W - 1));

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];

  logic [IW-1:0]     l_idx;
  logic [TAG_W-1:0]  l_tag;
  logic              l_hit;
  logic [CNT_W-1:0]  l_cnt;
  logic [IW-1:0]     u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              u_hit;
  logic              u_wr;
  cnt_op_t           u_op;
  logic              unused_pc;

  assign unused_pc = ^{if_pc, upd_pc};

  // Fetch-side lookup sees the tables as they stand before this cycle's update.
  assign l_idx       = if_pc[TAG_LO-1:2];
  assign l_tag       = if_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = l_hit && (l_cnt >= THR);
  assign pred_target = pred_taken ? target_q[l_idx] : if_pc + PC_W'(4);

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

  assign u_idx = upd_pc[TAG_LO-1:2];
  assign u_tag = upd_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_wr  = upd_valid && (u_hit || upd_taken);

  // Jumps pin the counter high; a taken miss allocates as weakly taken.
  always_comb begin
    u_op = CNT_SAT;
    if (!upd_is_br)  u_op = CNT_SET_MAX;
    else if (!u_hit) u_op = CNT_SET_WEAK_T;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (u_wr) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (u_wr) begin
      tag_q[u_idx] <= u_tag;
      if (upd_taken) target_q[u_idx] <= upd_target;
    end
  end

  bp_sat_counter_array #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (l_idx),
    .rd_cnt   (l_cnt),
    .wr_en    (u_wr),
    .wr_idx   (u_idx),
    .wr_op    (u_op),
    .wr_taken (upd_taken)
  );

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
      stat_btb_hits <= '0;
    end else begin
      if (upd_valid)  stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispred  <= stat_mispred + 32'd1;
      if (l_hit)      stat_btb_hits <= stat_btb_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor at default parameters (64 entries,
// 8-bit tags, 2-bit counters); stats counters checked when BP_STATS_EN is set.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic        upd_is_br;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
  logic [31:0] stat_btb_hits;
`endif

  int n_checks;
  int n_pass;

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_is_br       (upd_is_br),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispred    (stat_mispred),
    .stat_btb_hits   (stat_btb_hits)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic is_br, input logic taken,
                           input logic [31:0] target, input logic ptaken,
                           input logic [31:0] ptarget);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_br       = is_br;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptarget;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    if_pc    = 32'h100;
    drive_upd(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    #2;
    check_eq("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    check_eq("rst_pred_target", pred_target, 32'h104);
    check_eq("rst_mispredict", {31'b0, mispredict}, 32'd0);
    tick();
    rst = 1'b1;

    // First taken resolve at 0x100: miss, allocate weakly taken.
    drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    check_eq("cold_pred_taken", {31'b0, pred_taken}, 32'd0);
    check_eq("cold_pred_target", pred_target, 32'h104);
    check_eq("alloc_mispredict", {31'b0, mispredict}, 32'd1);
    check_eq("alloc_redirect", redirect_pc, 32'h80);
    tick();

    idle();
    #1;
    check_eq("hit_pred_taken", {31'b0, pred_taken}, 32'd1);
    check_eq("hit_pred_target", pred_target, 32'h80);
    drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
    #1;
    check_eq("match_mispredict", {31'b0, mispredict}, 32'd0);
    tick();
    tick();

    // Counter at 3: not-taken twice must walk down 2 then 1.
    drive_upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    check_eq("exit_mispredict", {31'b0, mispredict}, 32'd1);
    check_eq("exit_redirect", redirect_pc, 32'h104);
    tick();
    idle();
    #1;
    check_eq("sat_hi_pred", {31'b0, pred_taken}, 32'd1);
    drive_upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    idle();
    #1;
    check_eq("exit2_pred", {31'b0, pred_taken}, 32'd0);
    check_eq("exit2_target", pred_target, 32'h104);
    drive_upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
    #1;
    check_eq("nt_match_mispredict", {31'b0, mispredict}, 32'd0);
    tick();
    drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    idle();
    #1;
    check_eq("sat_lo_pred", {31'b0, pred_taken}, 32'd0);
    drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    idle();
    #1;
    check_eq("recover_pred", {31'b0, pred_taken}, 32'd1);
    check_eq("recover_target", pred_target, 32'h80);
    drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();

    // Alias: 0x200 shares index 0 with 0x100 and replaces it.
    drive_upd(32'h200, 1'b1, 1'b1, 32'h40, 1'b0, 32'h204);
    #1;
    check_eq("alias_mispredict", {31'b0, mispredict}, 32'd1);
    check_eq("alias_redirect", redirect_pc, 32'h40);
    tick();
    idle();
    #1;
    check_eq("alias_old_pred", {31'b0, pred_taken}, 32'd0);
    check_eq("alias_old_target", pred_target, 32'h104);
    if_pc = 32'h200;
    #1;
    check_eq("alias_new_pred", {31'b0, pred_taken}, 32'd1);
    check_eq("alias_new_target", pred_target, 32'h40);
    drive_upd(32'h200, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    check_eq("alias_nt_redirect", redirect_pc, 32'h204);
    tick();
    idle();
    #1;
    check_eq("alloc_weak_pred", {31'b0, pred_taken}, 32'd0);
    check_eq("alloc_weak_target", pred_target, 32'h204);

    // Jump allocates with a saturated counter.
    drive_upd(32'h10C, 1'b0, 1'b1, 32'h400, 1'b0, 32'h110);
    tick();
    idle();
    if_pc = 32'h10C;
    #1;
    check_eq("jal_pred", {31'b0, pred_taken}, 32'd1);
    check_eq("jal_target", pred_target, 32'h400);
    drive_upd(32'h10C, 1'b1, 1'b0, 32'h400, 1'b1, 32'h400);
    tick();
    idle();
    #1;
    check_eq("jal_max_pred", {31'b0, pred_taken}, 32'd1);
    drive_upd(32'h10C, 1'b0, 1'b1, 32'h500, 1'b1, 32'h400);
    #1;
    check_eq("tgt_mispredict", {31'b0, mispredict}, 32'd1);
    check_eq("tgt_redirect", redirect_pc, 32'h500);
    tick();
    idle();
    #1;
    check_eq("tgt_new_target", pred_target, 32'h500);

    // Same-cycle lookup and update: no bypass.
    if_pc = 32'h300;
    drive_upd(32'h300, 1'b1, 1'b1, 32'h20, 1'b0, 32'h304);
    #1;
    check_eq("coll_same_pred", {31'b0, pred_taken}, 32'd0);
    check_eq("coll_same_target", pred_target, 32'h304);
    tick();
    idle();
    #1;
    check_eq("coll_next_pred", {31'b0, pred_taken}, 32'd1);
    check_eq("coll_next_target", pred_target, 32'h20);

    // Reset across an update edge drops the update and clears the tables.
    if_pc = 32'h114;
    drive_upd(32'h114, 1'b1, 1'b1, 32'h60, 1'b0, 32'h118);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_pred", {31'b0, pred_taken}, 32'd0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check_eq("rst_lost_pred", {31'b0, pred_taken}, 32'd0);
    check_eq("rst_lost_target", pred_target, 32'h118);
    if_pc = 32'h300;
    #1;
    check_eq("rst_clear_pred", {31'b0, pred_taken}, 32'd0);
    check_eq("rst_clear_target", pred_target, 32'h304);

`ifdef BP_STATS_EN
    if_pc = 32'h7F0;
    for (int i = 0; i < 10; i++) begin
      drive_upd(32'h900 + 32'(i * 4), 1'b1, 1'b0, 32'h0, (i < 3), 32'h0);
      tick();
    end
    idle();
    #1;
    check_eq("stat_branches", stat_branches, 32'd10);
    check_eq("stat_mispred", stat_mispred, 32'd3);
    check_eq("stat_btb_hits", stat_btb_hits, 32'd0);
`endif

    // Resolution is gated by upd_valid; redirect is not.
    upd_valid       = 1'b0;
    upd_pc          = 32'hFFFF_FFFC;
    upd_taken       = 1'b0;
    upd_pred_taken  = 1'b1;
    #1;
    check_eq("novalid_mispredict", {31'b0, mispredict}, 32'd0);
    check_eq("wrap_redirect", redirect_pc, 32'h0);
    if_pc = 32'hFFFF_FFFC;
    #1;
    check_eq("wrap_pred_target", pred_target, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
